fetch_budget_ctrl: RTL and testbench
====================================

Name: fetch_budget_ctrl

Overview:
- Per-run instruction-budget controller for the multi-core verification harness.
- Gates the fetch enable of NUM_CH cores so each core fetches exactly a programmed number of instructions.
- Then waits for every fetched instruction to retire, with a watchdog, and reports finished or timeout.
- Sits between the testbench top and the cores' fetch/commit interfaces.

Parameters:
- NUM_CH, 2, number of core channels (1..8).
- CNT_W, 32, width of fetch/retire counters and of the budget.
- DRAIN_W, 16, width of the drain watchdog counter.
- DRAIN_MAX, 16'd1000, cycles allowed in DRAIN before timeout.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  pulse: latch budget and begin a run (accepted only in IDLE or DONE).
- budget_i  in  CNT_W  instructions each channel may fetch, sampled on the accepted start_i.
- fetch_i  in  NUM_CH  per-channel fetch strobe, one instruction per cycle.
- retire_i  in  NUM_CH  per-channel retire strobe, one instruction per cycle.
- enable_o  out  NUM_CH  per-channel fetch enable.
- running_o  out  1  high in RUN or DRAIN.
- finished_o  out  1  run complete, all fetched instructions retired.
- timeout_o  out  1  drain watchdog expired.
- overrun_o  out  NUM_CH  sticky: a channel retired more than it fetched.
- fetch_cnt_o  out  NUM_CH*CNT_W  per-channel fetch counts; channel c at bits [c*CNT_W +: CNT_W].

Behaviour:
- Reset (rst_i=1 at clk edge): state=IDLE; all counters, the budget register and the watchdog cleared; enable_o=0, running_o=0, finished_o=0, timeout_o=0, overrun_o=0. Applies from any state and abandons a run in progress.
- States: IDLE, RUN, DRAIN, DONE. All outputs are registered.
- IDLE/DONE + start_i:
  - Latch budget_i; clear fetch/retire counters, overrun_o, finished_o, timeout_o and the watchdog.
  - budget_i != 0: next state RUN, enable_o = all ones on the following cycle.
  - budget_i == 0: next state DRAIN, enable_o stays 0.
- start_i in RUN or DRAIN is ignored.
- Fetch counting:
  - A fetch on channel c counts only when enable_o[c] && fetch_i[c] in that cycle. Fetch strobes while enable_o[c]=0 are ignored.
  - When a counted fetch brings fcnt[c] to the budget, enable_o[c] is cleared at the same edge. Exactly budget fetches are counted per channel.
  - enable_o[c] never re-asserts within a run.
- RUN -> DRAIN at the edge where the last enable_o bit clears, or when all bits are already clear.
- Retire counting:
  - In RUN and DRAIN, retire_i[c] increments rcnt[c].
  - If retire_i[c] arrives when rcnt[c] == fcnt[c] (including same-cycle fetch accounting), set overrun_o[c] sticky and do not increment rcnt[c].
  - Retire strobes in IDLE/DONE are ignored.
- DRAIN:
  - Watchdog increments every DRAIN cycle.
  - If rcnt[c] == fcnt[c] for all c: next state DONE, finished_o=1.
  - Else if watchdog == DRAIN_MAX-1: next state DONE, timeout_o=1, finished_o=0.
  - Completion takes priority over timeout in the same cycle.
- DONE: finished_o/timeout_o held until a new accepted start_i or reset. running_o=0.
- Widths:
  - Counters never exceed the budget, so no wrap.
  - budget_i = 2^CNT_W-1 is legal.
  - Comparisons are unsigned, CNT_W bits.
- Simultaneous fetch and retire on a channel in one cycle are both processed.

Test Plan:
- Reset, start_i with budget_i=5, fetch_i=2'b11 every cycle, retire_i=fetch_i delayed 3 cycles -> each enable_o bit high exactly 5 cycles; fetch_cnt=5,5; finished_o=1 two cycles after the last retire; timeout_o=0.
- budget_i=3, channel 0 fetches continuously, channel 1 fetches every 4th cycle -> enable_o[0] drops after the 3rd ch0 fetch while enable_o[1] stays high; state enters DRAIN only after the 3rd ch1 fetch.
- budget_i=4, only 3 retires on ch1 -> timeout_o=1 exactly DRAIN_MAX cycles after DRAIN entry; finished_o=0.
- budget_i=0 -> enable_o never rises; finished_o=1 two cycles after start_i.
- Extra retire on ch0 with rcnt=fcnt=2 -> overrun_o[0]=1 sticky, rcnt[0] stays 2; cleared by the next start_i.
- rst_i mid-RUN with fetch_cnt=2 -> next cycle all outputs 0, state IDLE; a new start_i with budget_i=1 runs cleanly from count 0.

Source files
------------

// File: rtl/fetch_budget_ctrl.sv
// fetch_budget_ctrl
//
// Per-run instruction-budget controller for the multi-core verification
// harness. On an accepted start it latches a per-channel fetch budget,
// opens the fetch enable of every core, closes each one as soon as that
// core has fetched exactly the budgeted number of instructions, and then
// waits (under a watchdog) for every fetched instruction to retire.
//
// Ports:
//   clk_i        clock, all logic on the rising edge
//   rst_i        synchronous active-high reset
//   start_i      begin a run (accepted only in IDLE or DONE)
//   budget_i     instructions each channel may fetch, sampled on start
//   fetch_i      per-channel fetch strobe
//   retire_i     per-channel retire strobe
//   enable_o     per-channel fetch enable
//   running_o    high while in RUN or DRAIN
//   finished_o   run complete, every fetched instruction retired
//   timeout_o    drain watchdog expired
//   overrun_o    sticky per channel: retired more than it fetched
//   fetch_cnt_o  per-channel fetch counts, channel c at [c*CNT_W +: CNT_W]

module fetch_budget_ctrl #(
  parameter int                 NUM_CH    = 2,
  parameter int                 CNT_W     = 32,
  parameter int                 DRAIN_W   = 16,
  parameter logic [DRAIN_W-1:0] DRAIN_MAX = 16'd1000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [CNT_W-1:0]        budget_i,
  input  logic [NUM_CH-1:0]       fetch_i,
  input  logic [NUM_CH-1:0]       retire_i,
  output logic [NUM_CH-1:0]       enable_o,
  output logic                    running_o,
  output logic                    finished_o,
  output logic                    timeout_o,
  output logic [NUM_CH-1:0]       overrun_o,
  output logic [NUM_CH*CNT_W-1:0] fetch_cnt_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_MAX - DRAIN_W'(1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   budget_q;
  logic [CNT_W-1:0]   fcnt [NUM_CH];
  logic [CNT_W-1:0]   rcnt [NUM_CH];
  logic [DRAIN_W-1:0] wdog;
  logic [NUM_CH-1:0]  enable_q;
  logic [NUM_CH-1:0]  overrun_q;
  logic               running_q;
  logic               finished_q;
  logic               timeout_q;

  logic               active;
  logic               all_retired;
  logic [NUM_CH-1:0]  fetch_hit;
  logic [NUM_CH-1:0]  last_fetch;
  logic [NUM_CH-1:0]  retire_ok;
  logic [NUM_CH-1:0]  retire_bad;
  logic [NUM_CH-1:0]  enable_nxt;
  logic [CNT_W-1:0]   fcnt_nxt [NUM_CH];

  // Per-channel accounting for the current cycle. A retire is judged
  // against the fetch count including a fetch counted in this same cycle,
  // so a core that fetches and retires together is never flagged.
  // Completion is judged on the registered counts only.
  always_comb begin
    active      = (state == ST_RUN) || (state == ST_DRAIN);
    all_retired = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      fetch_hit[c]  = enable_q[c] & fetch_i[c];
      fcnt_nxt[c]   = fetch_hit[c] ? (fcnt[c] + CNT_W'(1)) : fcnt[c];
      last_fetch[c] = fetch_hit[c] && (fcnt_nxt[c] == budget_q);
      retire_bad[c] = active && retire_i[c] && (rcnt[c] == fcnt_nxt[c]);
      retire_ok[c]  = active && retire_i[c] && (rcnt[c] != fcnt_nxt[c]);
      if (rcnt[c] != fcnt[c]) begin
        all_retired = 1'b0;
      end
    end
    enable_nxt = enable_q & ~last_fetch;
  end

  // Run sequencing. Counting happens in RUN and DRAIN; the enables are
  // already zero in DRAIN, so only retires move there. The start branch
  // lives in IDLE/DONE where counting is inactive, so the two never
  // compete for the counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      budget_q   <= '0;
      wdog       <= '0;
      enable_q   <= '0;
      overrun_q  <= '0;
      running_q  <= 1'b0;
      finished_q <= 1'b0;
      timeout_q  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        fcnt[c] <= '0;
        rcnt[c] <= '0;
      end
    end else begin
      if (active) begin
        for (int c = 0; c < NUM_CH; c++) begin
          fcnt[c] <= fcnt_nxt[c];
          if (retire_ok[c]) begin
            rcnt[c] <= rcnt[c] + CNT_W'(1);
          end
        end
        overrun_q <= overrun_q | retire_bad;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            budget_q   <= budget_i;
            wdog       <= '0;
            overrun_q  <= '0;
            finished_q <= 1'b0;
            timeout_q  <= 1'b0;
            running_q  <= 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
              fcnt[c] <= '0;
              rcnt[c] <= '0;
            end
            // A zero budget has nothing to fetch and goes straight to drain.
            if (budget_i != '0) begin
              state    <= ST_RUN;
              enable_q <= '1;
            end else begin
              state    <= ST_DRAIN;
              enable_q <= '0;
            end
          end
        end

        ST_RUN: begin
          enable_q <= enable_nxt;
          if (enable_nxt == '0) begin
            state <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          wdog <= wdog + DRAIN_W'(1);
          // Completion wins over an expiring watchdog in the same cycle.
          if (all_retired) begin
            state      <= ST_DONE;
            finished_q <= 1'b1;
            running_q  <= 1'b0;
          end else if (wdog == DRAIN_LAST) begin
            state      <= ST_DONE;
            timeout_q  <= 1'b1;
            running_q  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign enable_o   = enable_q;
  assign running_o  = running_q;
  assign finished_o = finished_q;
  assign timeout_o  = timeout_q;
  assign overrun_o  = overrun_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign fetch_cnt_o[g*CNT_W +: CNT_W] = fcnt[g];
  end

endmodule

// File: tb/tb_fetch_budget_ctrl.sv
// tb_fetch_budget_ctrl
//
// Directed bench for fetch_budget_ctrl. Stimulus pushes cycle-tagged
// expected output values into a scoreboard queue; a monitor running on the
// falling edge pops every expectation due in the current cycle and
// compares it against the DUT outputs.

module tb_fetch_budget_ctrl;

  localparam int                NUM_CH    = 2;
  localparam int                CNT_W     = 32;
  localparam int                DRAIN_W   = 16;
  localparam logic [DRAIN_W-1:0] DRAIN_MAX = 16'd1000;

  localparam int F_EN  = 0;
  localparam int F_RUN = 1;
  localparam int F_FIN = 2;
  localparam int F_TO  = 3;
  localparam int F_OVR = 4;
  localparam int F_CNT = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [CNT_W-1:0]        budget;
  logic [NUM_CH-1:0]       fetch;
  logic [NUM_CH-1:0]       retire;
  logic [NUM_CH-1:0]       enable;
  logic                    running;
  logic                    finished;
  logic                    timeout;
  logic [NUM_CH-1:0]       overrun;
  logic [NUM_CH*CNT_W-1:0] fetch_cnt;

  typedef struct {
    int          at_cyc;
    int          field;
    logic [63:0] value;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  fetch_budget_ctrl #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DRAIN_W  (DRAIN_W),
    .DRAIN_MAX(DRAIN_MAX)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .budget_i   (budget),
    .fetch_i    (fetch),
    .retire_i   (retire),
    .enable_o   (enable),
    .running_o  (running),
    .finished_o (finished),
    .timeout_o  (timeout),
    .overrun_o  (overrun),
    .fetch_cnt_o(fetch_cnt)
  );

  // Free-running clock and edge counter used to tag expectations.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] sample(input int field);
    case (field)
      F_EN:    return 64'(enable);
      F_RUN:   return 64'(running);
      F_FIN:   return 64'(finished);
      F_TO:    return 64'(timeout);
      F_OVR:   return 64'(overrun);
      default: return 64'(fetch_cnt);
    endcase
  endfunction

  // Drive one cycle of inputs just after the rising edge, then advance.
  task automatic applyStimulus(input logic s, input logic [CNT_W-1:0] b,
                               input logic [NUM_CH-1:0] f,
                               input logic [NUM_CH-1:0] r, input logic rs);
    start  = s;
    budget = b;
    fetch  = f;
    retire = r;
    rst    = rs;
    @(posedge clk);
    #1;
  endtask

  // Queue an expected output value for the given absolute cycle.
  task automatic checkOutput(input int at, input int field,
                             input logic [63:0] v, input string name);
    exp_t e;
    e.at_cyc = at;
    e.field  = field;
    e.value  = v;
    e.name   = name;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation that falls due this cycle; any that
  // slipped into the past without being sampled counts as a failure.
  initial begin
    logic [63:0] act;
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at_cyc <= cyc) begin
          act = sample(sb[i].field);
          checks++;
          if (sb[i].at_cyc < cyc) begin
            errors++;
            $display("[TB] FAIL %s: expectation for cycle %0d not sampled (now %0d)",
                     sb[i].name, sb[i].at_cyc, cyc);
          end else if (act !== sb[i].value) begin
            errors++;
            $display("[TB] FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h",
                     sb[i].name, cyc, act, sb[i].value);
          end
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    #(50000 * 10);
    $display("[TB] FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d",
             checks, errors);
    $fatal(1, "[TB] global time limit reached");
  end

  initial begin
    int t;
    rst    = 1'b1;
    start  = 1'b0;
    budget = '0;
    fetch  = '0;
    retire = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    t = cyc;
    checkOutput(t, F_EN,  0, "reset_enable");
    checkOutput(t, F_RUN, 0, "reset_running");
    checkOutput(t, F_FIN, 0, "reset_finished");
    checkOutput(t, F_TO,  0, "reset_timeout");
    checkOutput(t, F_OVR, 0, "reset_overrun");
    checkOutput(t, F_CNT, 0, "reset_fetch_cnt");
    repeat (2) applyStimulus(0, 0, 2'b00, 2'b00, 0);

    // Budget 5, both channels fetching, retires trail by three cycles.
    $display("[TB] scenario 1: budget 5, full-rate fetch");
    t = cyc;
    checkOutput(t, F_EN, 0, "s1_enable_before");
    for (int i = 1; i <= 5; i++) checkOutput(t + i, F_EN, 2'b11, "s1_enable_on");
    checkOutput(t + 6,  F_EN,  0, "s1_enable_off");
    checkOutput(t + 6,  F_CNT, {32'd5, 32'd5}, "s1_fetch_cnt");
    checkOutput(t + 9,  F_RUN, 1, "s1_running_drain");
    checkOutput(t + 9,  F_FIN, 0, "s1_finished_early");
    checkOutput(t + 10, F_FIN, 1, "s1_finished");
    checkOutput(t + 10, F_TO,  0, "s1_timeout");
    checkOutput(t + 10, F_RUN, 0, "s1_running_done");
    for (int i = 0; i < 13; i++)
      applyStimulus(i == 0, 5, 2'b11, (i >= 4 && i <= 8) ? 2'b11 : 2'b00, 0);

    // Budget 3, ch1 fetching every 4th cycle; a start mid-run is ignored.
    $display("[TB] scenario 2: budget 3, uneven fetch rates");
    t = cyc;
    checkOutput(t + 3,  F_EN,  2'b11, "s2_enable_both");
    checkOutput(t + 4,  F_EN,  2'b10, "s2_enable_ch0_off");
    checkOutput(t + 9,  F_EN,  2'b10, "s2_enable_ch1_held");
    checkOutput(t + 10, F_EN,  2'b00, "s2_enable_off");
    checkOutput(t + 10, F_RUN, 1, "s2_running");
    checkOutput(t + 10, F_CNT, {32'd3, 32'd3}, "s2_fetch_cnt");
    checkOutput(t + 11, F_FIN, 0, "s2_finished_early");
    checkOutput(t + 12, F_FIN, 1, "s2_finished");
    checkOutput(t + 12, F_OVR, 0, "s2_overrun");
    for (int i = 0; i < 14; i++) begin
      logic [1:0] f;
      logic [1:0] r;
      f[0] = (i >= 1);
      f[1] = (i == 1) || (i == 5) || (i == 9);
      r[0] = (i >= 2) && (i <= 4);
      r[1] = (i == 2) || (i == 6) || (i == 10);
      applyStimulus((i == 0) || (i == 6), (i == 0) ? 3 : 0, f, r, 0);
    end

    // Budget 4, ch1 retires only three: drain watchdog fires.
    $display("[TB] scenario 3: missing retire, watchdog timeout");
    t = cyc;
    checkOutput(t + 4,    F_EN,  2'b11, "s3_enable_last");
    checkOutput(t + 5,    F_EN,  0, "s3_enable_off");
    checkOutput(t + 1004, F_RUN, 1, "s3_running_before_to");
    checkOutput(t + 1004, F_TO,  0, "s3_timeout_early");
    checkOutput(t + 1005, F_TO,  1, "s3_timeout");
    checkOutput(t + 1005, F_FIN, 0, "s3_finished");
    checkOutput(t + 1005, F_RUN, 0, "s3_running_done");
    for (int i = 0; i < 1008; i++) begin
      logic [1:0] r;
      r[0] = (i >= 2) && (i <= 5);
      r[1] = (i >= 2) && (i <= 4);
      applyStimulus(i == 0, 4, (i >= 1 && i <= 4) ? 2'b11 : 2'b00, r, 0);
    end

    // Budget 0: no fetch enable, straight through drain.
    $display("[TB] scenario 4: zero budget");
    t = cyc;
    checkOutput(t + 1, F_EN,  0, "s4_enable_1");
    checkOutput(t + 1, F_RUN, 1, "s4_running");
    checkOutput(t + 1, F_FIN, 0, "s4_finished_early");
    checkOutput(t + 1, F_TO,  0, "s4_timeout_cleared");
    checkOutput(t + 2, F_EN,  0, "s4_enable_2");
    checkOutput(t + 2, F_FIN, 1, "s4_finished");
    checkOutput(t + 2, F_TO,  0, "s4_timeout");
    checkOutput(t + 2, F_CNT, 0, "s4_fetch_cnt");
    for (int i = 0; i < 4; i++) applyStimulus(i == 0, 0, 2'b11, 2'b00, 0);

    // Budget 2: extra retire on ch0 once rcnt == fcnt == 2.
    $display("[TB] scenario 5: retire overrun");
    t = cyc;
    checkOutput(t + 2,  F_OVR, 0, "s5_same_cycle_fetch_retire");
    checkOutput(t + 3,  F_EN,  0, "s5_enable_off");
    checkOutput(t + 4,  F_OVR, 0, "s5_overrun_before");
    checkOutput(t + 5,  F_OVR, 2'b01, "s5_overrun_set");
    checkOutput(t + 8,  F_FIN, 0, "s5_finished_early");
    checkOutput(t + 9,  F_FIN, 1, "s5_finished");
    checkOutput(t + 9,  F_TO,  0, "s5_timeout");
    checkOutput(t + 11, F_OVR, 2'b01, "s5_overrun_sticky");
    for (int i = 0; i < 12; i++) begin
      logic [1:0] r;
      r[0] = (i >= 2 && i <= 4) || (i == 10);
      r[1] = (i == 1) || (i == 7);
      applyStimulus(i == 0, 2, (i >= 1) ? 2'b11 : 2'b00, r, 0);
    end

    // Reset in the middle of a run, then a clean budget-1 run.
    $display("[TB] scenario 6: reset mid-run");
    t = cyc;
    checkOutput(t + 1, F_OVR, 0, "s6_overrun_cleared");
    checkOutput(t + 3, F_EN,  2'b11, "s6_enable_mid");
    checkOutput(t + 3, F_CNT, {32'd2, 32'd2}, "s6_fetch_cnt_mid");
    checkOutput(t + 4, F_EN,  0, "s6_rst_enable");
    checkOutput(t + 4, F_RUN, 0, "s6_rst_running");
    checkOutput(t + 4, F_FIN, 0, "s6_rst_finished");
    checkOutput(t + 4, F_TO,  0, "s6_rst_timeout");
    checkOutput(t + 4, F_OVR, 0, "s6_rst_overrun");
    checkOutput(t + 4, F_CNT, 0, "s6_rst_fetch_cnt");
    checkOutput(t + 5, F_EN,  0, "s6_idle_enable");
    for (int i = 0; i < 6; i++) applyStimulus(i == 0, 5, 2'b11, 2'b00, i == 3);

    t = cyc;
    checkOutput(t + 1, F_EN,  2'b11, "s6b_enable_on");
    checkOutput(t + 2, F_EN,  0, "s6b_enable_off");
    checkOutput(t + 2, F_CNT, {32'd1, 32'd1}, "s6b_fetch_cnt");
    checkOutput(t + 3, F_FIN, 0, "s6b_finished_early");
    checkOutput(t + 4, F_FIN, 1, "s6b_finished");
    checkOutput(t + 4, F_OVR, 0, "s6b_overrun");
    for (int i = 0; i < 7; i++)
      applyStimulus(i == 0, 1, 2'b11, (i == 2) ? 2'b11 : 2'b00, 0);

    // Let the monitor flush anything still pending, bounded.
    for (int i = 0; i < 20 && sb.size() > 0; i++) applyStimulus(0, 0, 2'b00, 2'b00, 0);
    applyStimulus(0, 0, 2'b00, 2'b00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
